// File: rtl/ram_dp_pkg.sv
// Shared types, constants and helpers for the parametrised dual-port RAM.
// The parity helper is only referenced when RAM_DP_PARITY_EN is defined.
package ram_dp_pkg;

    // Clear-sweep controller states
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // Read-during-write modes (values of WR_MODE)
    localparam int RD_FIRST = 0;
    localparam int WR_FIRST = 1;

    // Widest word the parity helper accepts; narrower words are zero-extended,
    // which leaves the XOR reduction unchanged.
    localparam int PARITY_MAX_W = 64;

    // Even-parity bit: makes the total number of ones (data + parity) even
    function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/ram_dp_clear_ctrl.sv
// Clear-on-reset sweep controller for ram_dp_param.
// After reset (when CLEAR_ON_RST = 1) it walks every address once, driving a
// zero-data write override onto port 1's write path, and flags busy meanwhile.
module ram_dp_clear_ctrl
    import ram_dp_pkg::*;
#(
    parameter int ADDR_W       = 15,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] ptr;

    // State register: reset restarts the sweep, even when one is already running
    always_ff @(posedge clk) begin
        // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
        if (rst) begin
            state <= (CLEAR_ON_RST != 0) ? CLEAR : IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Sweep pointer: advances once per cleared word
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (state == CLEAR) begin
            ptr <= ptr + 1'b1;
        end
    end

    // Next state: leave CLEAR after the last address has been written
    always_comb begin
        // NOTE: default assignment first so no path leaves next_state unassigned (no latch).
        next_state = state;
        case (state)
            CLEAR:   if (&ptr) next_state = IDLE;
            default: next_state = state;
        endcase
    end

    // Outputs: busy and the zero-write override follow the CLEAR state directly
    always_comb begin
        busy     = 1'b0;
        clr_we   = 1'b0;
        clr_addr = ptr;
        if (state == CLEAR) begin
            busy   = 1'b1;
            clr_we = 1'b1;
        end
    end

endmodule

// File: rtl/ram_dp_param.sv
// Parametrised true dual-port synchronous RAM.
// Per-port enables, registered reads with valid strobes, selectable
// read-during-write mode, same-address write collision reporting (port 1 wins)
// and an optional clear-on-reset sweep.
// Optional feature: define RAM_DP_PARITY_EN to store an even-parity bit per
// word and flag mismatches on read via parity_err_1 / parity_err_2.
module ram_dp_param
    import ram_dp_pkg::*;
#(
    parameter int DATA_W       = 4,
    parameter int ADDR_W       = 15,
    parameter int WR_MODE      = 1,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_1,
    input  logic              rw_1,
    input  logic [ADDR_W-1:0] address_1,
    input  logic [DATA_W-1:0] data_in_1,
    output logic [DATA_W-1:0] data_out_1,
    output logic              valid_1,
    input  logic              en_2,
    input  logic              rw_2,
    input  logic [ADDR_W-1:0] address_2,
    input  logic [DATA_W-1:0] data_in_2,
    output logic [DATA_W-1:0] data_out_2,
    output logic              valid_2,
    output logic              busy,
    output logic              collision,
    output logic              parity_err_1,
    output logic              parity_err_2
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    logic              access_ok;
    logic              same_addr;
    logic              usr_we_1;
    logic              req_we_2;
    logic              wr_en_1;
    logic [ADDR_W-1:0] wr_addr_1;
    logic [DATA_W-1:0] wr_data_1;
    logic              wr_en_2;
    logic              rd_1;
    logic              rd_2;
    logic [DATA_W-1:0] rd_data_1;
    logic [DATA_W-1:0] rd_data_2;

    ram_dp_clear_ctrl #(
        .ADDR_W       (ADDR_W),
        .CLEAR_ON_RST (CLEAR_ON_RST)
    ) u_clear_ctrl (
        .clk      (clk),
        .rst      (rst),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // Request decode: user traffic is ignored while sweeping or in reset
    always_comb begin
        access_ok = !busy && !rst;
        same_addr = (address_1 == address_2);
        usr_we_1  = access_ok && en_1 && rw_1;
        req_we_2  = access_ok && en_2 && rw_2;
        rd_1      = access_ok && en_1 && !rw_1;
        rd_2      = access_ok && en_2 && !rw_2;
        // Port 2 loses a same-address write race to port 1
        wr_en_2   = req_we_2 && !(usr_we_1 && same_addr);
        // Clear sweep overrides the port 1 write path
        wr_en_1   = busy ? clr_we   : usr_we_1;
        wr_addr_1 = busy ? clr_addr : address_1;
        wr_data_1 = busy ? '0       : data_in_1;
    end

    // Read data selection, with same-cycle write bypass in write-first mode
    always_comb begin
        rd_data_1 = mem[address_1];
        rd_data_2 = mem[address_2];
        if (WR_MODE == WR_FIRST) begin
            if (wr_en_2 && same_addr) rd_data_1 = data_in_2;
            if (usr_we_1 && same_addr) rd_data_2 = data_in_1;
        end
    end

    // Storage array write ports
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; clearing is done by the sweep, which keeps it mappable to RAM.
        if (wr_en_1) mem[wr_addr_1] <= wr_data_1;
        if (wr_en_2) mem[address_2] <= data_in_2;
    end

    // Registered read outputs, valid strobes and collision pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_1 <= '0;
            data_out_2 <= '0;
            valid_1    <= 1'b0;
            valid_2    <= 1'b0;
            collision  <= 1'b0;
        end else begin
            valid_1   <= rd_1;
            valid_2   <= rd_2;
            collision <= usr_we_1 && req_we_2 && same_addr;
            if (rd_1) data_out_1 <= rd_data_1;
            if (rd_2) data_out_2 <= rd_data_2;
        end
    end

`ifdef RAM_DP_PARITY_EN
    logic par_mem [DEPTH];
    logic par_in_1;
    logic par_in_2;
    logic rd_par_1;
    logic rd_par_2;

    // Parity of incoming write data; the sweep stores parity of zero
    always_comb begin
        par_in_1 = busy ? 1'b0 : even_parity(PARITY_MAX_W'(data_in_1));
        par_in_2 = even_parity(PARITY_MAX_W'(data_in_2));
        rd_par_1 = par_mem[address_1];
        rd_par_2 = par_mem[address_2];
        if (WR_MODE == WR_FIRST) begin
            if (wr_en_2 && same_addr) rd_par_1 = par_in_2;
            if (usr_we_1 && same_addr) rd_par_2 = par_in_1;
        end
    end

    // Parity storage, written alongside the data array
    always_ff @(posedge clk) begin
        if (wr_en_1) par_mem[wr_addr_1] <= par_in_1;
        if (wr_en_2) par_mem[address_2] <= par_in_2;
    end

    // Parity check registered alongside the valid strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err_1 <= 1'b0;
            parity_err_2 <= 1'b0;
        end else begin
            parity_err_1 <= rd_1 && (even_parity(PARITY_MAX_W'(rd_data_1)) != rd_par_1);
            parity_err_2 <= rd_2 && (even_parity(PARITY_MAX_W'(rd_data_2)) != rd_par_2);
        end
    end
`else
    // No parity storage: error flags are constant
    always_comb begin
        parity_err_1 = 1'b0;
        parity_err_2 = 1'b0;
    end
`endif

endmodule

// File: tb/tb_ram_dp_param.sv
// Self-checking bench for ram_dp_param (DATA_W=4, ADDR_W=4, CLEAR_ON_RST=1).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, so each check sees the result of the preceding edge.
module tb_ram_dp_param;

    localparam int DATA_W       = 4;
    localparam int ADDR_W       = 4;
    localparam int WR_MODE      = 1;
    localparam int CLEAR_ON_RST = 1;
    localparam int DEPTH        = 2 ** ADDR_W;

    // Read-during-write expectations depend on the mode under test
    localparam logic [3:0] RDW_A2 = (WR_MODE == 1) ? 4'hC : 4'h1;
    localparam logic [3:0] RDW_A5 = (WR_MODE == 1) ? 4'h6 : 4'h0;

    logic              clk = 1'b0;
    logic              rst;
    logic              en_1, rw_1, en_2, rw_2;
    logic [ADDR_W-1:0] address_1, address_2;
    logic [DATA_W-1:0] data_in_1, data_in_2;
    logic [DATA_W-1:0] data_out_1, data_out_2;
    logic              valid_1, valid_2, busy, collision;
    logic              parity_err_1, parity_err_2;

    int n_checks = 0;
    int n_fail   = 0;

    ram_dp_param #(
        .DATA_W       (DATA_W),
        .ADDR_W       (ADDR_W),
        .WR_MODE      (WR_MODE),
        .CLEAR_ON_RST (CLEAR_ON_RST)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en_1         (en_1),
        .rw_1         (rw_1),
        .address_1    (address_1),
        .data_in_1    (data_in_1),
        .data_out_1   (data_out_1),
        .valid_1      (valid_1),
        .en_2         (en_2),
        .rw_2         (rw_2),
        .address_2    (address_2),
        .data_in_2    (data_in_2),
        .data_out_2   (data_out_2),
        .valid_2      (valid_2),
        .busy         (busy),
        .collision    (collision),
        .parity_err_1 (parity_err_1),
        .parity_err_2 (parity_err_2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en1, rw1;
        logic [3:0] a1, d1;
        logic       en2, rw2;
        logic [3:0] a2, d2;
        logic [3:0] e_out1;
        logic       e_v1;
        logic [3:0] e_out2;
        logic       e_v2;
        logic       e_col;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ports();
        en_1 = 1'b0; rw_1 = 1'b0; address_1 = '0; data_in_1 = '0;
        en_2 = 1'b0; rw_2 = 1'b0; address_2 = '0; data_in_2 = '0;
    endtask

    task automatic p1_op(input logic rw, input logic [3:0] a, input logic [3:0] d);
        en_1 = 1'b1; rw_1 = rw; address_1 = a; data_in_1 = d;
    endtask

    // Counts samples with busy high, starting right after a reset edge; valid must stay low
    task automatic count_busy(input string tag, output int cnt);
        cnt = 0;
        while (busy && cnt < 100) begin
            check({tag, " valid_1 while busy"}, 32'(valid_1), 32'd0);
            cnt++;
            tick();
        end
    endtask

    initial begin
        int cnt;

        // fields: en1 rw1 a1 d1 | en2 rw2 a2 d2 | out1 v1 out2 v2 col
        vecs[0]  = '{1, 1, 4'd3, 4'hA,  0, 0, 4'd0, 4'h0,  4'h0,   0, 4'h0,   0, 0};
        vecs[1]  = '{0, 0, 4'd0, 4'h0,  1, 0, 4'd3, 4'h0,  4'h0,   0, 4'hA,   1, 0};
        vecs[2]  = '{1, 1, 4'd7, 4'h5,  1, 1, 4'd7, 4'h9,  4'h0,   0, 4'hA,   0, 1};
        vecs[3]  = '{0, 0, 4'd0, 4'h0,  0, 0, 4'd0, 4'h0,  4'h0,   0, 4'hA,   0, 0};
        vecs[4]  = '{1, 0, 4'd7, 4'h0,  0, 0, 4'd0, 4'h0,  4'h5,   1, 4'hA,   0, 0};
        vecs[5]  = '{0, 0, 4'd0, 4'h0,  1, 1, 4'd2, 4'h1,  4'h5,   0, 4'hA,   0, 0};
        vecs[6]  = '{1, 1, 4'd2, 4'hC,  1, 0, 4'd2, 4'h0,  4'h5,   0, RDW_A2, 1, 0};
        vecs[7]  = '{1, 0, 4'd2, 4'h0,  1, 0, 4'd2, 4'h0,  4'hC,   1, 4'hC,   1, 0};
        vecs[8]  = '{1, 0, 4'd5, 4'h0,  1, 1, 4'd5, 4'h6,  RDW_A5, 1, 4'hC,   0, 0};
        vecs[9]  = '{1, 1, 4'd8, 4'hE,  1, 1, 4'd9, 4'hB,  RDW_A5, 0, 4'hC,   0, 0};
        vecs[10] = '{1, 0, 4'd8, 4'h0,  1, 0, 4'd9, 4'h0,  4'hE,   1, 4'hB,   1, 0};
        vecs[11] = '{0, 1, 4'd3, 4'hF,  0, 1, 4'd5, 4'hF,  4'hE,   0, 4'hB,   0, 0};
        vecs[12] = '{1, 0, 4'd3, 4'h0,  1, 0, 4'd5, 4'h0,  4'hA,   1, 4'h6,   1, 0};

        idle_ports();
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Reset state
        check("reset data_out_1", 32'(data_out_1), 32'd0);
        check("reset data_out_2", 32'(data_out_2), 32'd0);
        check("reset valid_2", 32'(valid_2), 32'd0);
        check("reset collision", 32'(collision), 32'd0);
        check("reset parity_err_1", 32'(parity_err_1), 32'd0);
        check("reset busy", 32'(busy), 32'd1);

        // Read request held during the whole sweep must be ignored
        p1_op(1'b0, 4'd0, 4'h0);
        count_busy("sweep1", cnt);
        check("sweep1 busy cycles", 32'(cnt), 32'(DEPTH));
        check("sweep1 valid_1 after busy", 32'(valid_1), 32'd0);
        idle_ports();

        // Every word reads zero after the sweep
        for (int i = 0; i < DEPTH; i++) begin
            en_1 = 1'b1; rw_1 = 1'b0; address_1 = ADDR_W'(i);
            en_2 = 1'b1; rw_2 = 1'b0; address_2 = ADDR_W'(DEPTH - 1 - i);
            tick();
            check($sformatf("clear rd1 a%0d", i), 32'(data_out_1), 32'd0);
            check($sformatf("clear v1 a%0d", i), 32'(valid_1), 32'd1);
            check($sformatf("clear rd2 a%0d", DEPTH - 1 - i), 32'(data_out_2), 32'd0);
            check($sformatf("clear v2 a%0d", DEPTH - 1 - i), 32'(valid_2), 32'd1);
        end
        idle_ports();
        tick();
        check("valid_1 drops after reads", 32'(valid_1), 32'd0);
        check("valid_2 drops after reads", 32'(valid_2), 32'd0);

        // Directed vector table
        for (int i = 0; i < NVEC; i++) begin
            en_1 = vecs[i].en1; rw_1 = vecs[i].rw1; address_1 = vecs[i].a1; data_in_1 = vecs[i].d1;
            en_2 = vecs[i].en2; rw_2 = vecs[i].rw2; address_2 = vecs[i].a2; data_in_2 = vecs[i].d2;
            tick();
            check($sformatf("v%0d data_out_1", i), 32'(data_out_1), 32'(vecs[i].e_out1));
            check($sformatf("v%0d valid_1", i), 32'(valid_1), 32'(vecs[i].e_v1));
            check($sformatf("v%0d data_out_2", i), 32'(data_out_2), 32'(vecs[i].e_out2));
            check($sformatf("v%0d valid_2", i), 32'(valid_2), 32'(vecs[i].e_v2));
            check($sformatf("v%0d collision", i), 32'(collision), 32'(vecs[i].e_col));
            check($sformatf("v%0d parity_err_1", i), 32'(parity_err_1), 32'd0);
            check($sformatf("v%0d parity_err_2", i), 32'(parity_err_2), 32'd0);
        end
        idle_ports();

        // Reset in the middle of a sweep restarts it from address 0
        p1_op(1'b1, 4'd15, 4'hF);
        tick();
        p1_op(1'b0, 4'd15, 4'h0);
        tick();
        check("a15 before sweep", 32'(data_out_1), 32'hF);
        idle_ports();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst clears data_out_1", 32'(data_out_1), 32'd0);
        check("rst clears valid_1", 32'(valid_1), 32'd0);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("sweep2 busy c%0d", i), 32'(busy), 32'd1);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        count_busy("sweep3", cnt);
        check("sweep restart busy cycles", 32'(cnt), 32'(DEPTH));
        p1_op(1'b0, 4'd15, 4'h0);
        en_2 = 1'b1; rw_2 = 1'b0; address_2 = 4'd3;
        tick();
        check("a15 after restart", 32'(data_out_1), 32'd0);
        check("a15 after restart valid", 32'(valid_1), 32'd1);
        check("a3 after restart", 32'(data_out_2), 32'd0);
        idle_ports();

        // Parity error reporting on a corrupted stored parity bit
        p1_op(1'b1, 4'd4, 4'h3);
        tick();
        idle_ports();
`ifdef RAM_DP_PARITY_EN
        dut.par_mem[4] = 1'b1;
`endif
        p1_op(1'b0, 4'd4, 4'h0);
        tick();
        check("parity rd data", 32'(data_out_1), 32'h3);
        check("parity rd valid", 32'(valid_1), 32'd1);
`ifdef RAM_DP_PARITY_EN
        check("parity_err_1 on corrupt word", 32'(parity_err_1), 32'd1);
`else
        check("parity_err_1 tied low", 32'(parity_err_1), 32'd0);
`endif
        idle_ports();
        tick();
        check("parity_err_1 one cycle", 32'(parity_err_1), 32'd0);
        check("parity_err_2 quiet", 32'(parity_err_2), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
